// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if
//   Bus bundle between the two requesters, the arbiter and the SDRAM command
//   sequencer. Only clk_25mhz and rst are kept out of this bundle.
//   Signals:
//     m0_*/m1_*   requester handshake (req/we/addr/wdata in, ack/rdata out)
//     ctl_*       command handshake toward the controller (req/refresh/we/
//                 addr/wdata out, done/rdata in)
//     ref_overrun sticky refresh overrun flag
//   Modports:
//     slave  - the arbiter's view
//     master - the view of the logic around the arbiter (requesters plus
//              controller), used by the testbench
interface sdram_arbiter_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 16
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  logic              ctl_req;
  logic              ctl_refresh;
  logic              ctl_we;
  logic [ADDR_W-1:0] ctl_addr;
  logic [DATA_W-1:0] ctl_wdata;
  logic              ctl_done;
  logic [DATA_W-1:0] ctl_rdata;

  logic              ref_overrun;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  ctl_done, ctl_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output ctl_req, ctl_refresh, ctl_we, ctl_addr, ctl_wdata,
    output ref_overrun
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output ctl_done, ctl_rdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  ctl_req, ctl_refresh, ctl_we, ctl_addr, ctl_wdata,
    input  ref_overrun
  );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares one SDRAM command sequencer between two single-word requesters and
//   inserts periodic auto-refresh ahead of both. One transaction is in flight
//   at a time: IDLE picks a winner, BUSY holds the command until ctl_done,
//   ACK returns a one-cycle completion pulse (with read data) to the owner.
//   Ports:
//     clk_25mhz  sole clock
//     rst        synchronous, active-high reset (aborts any transaction)
//     bus        sdram_arbiter_if.slave (requester and controller handshakes,
//                ref_overrun status)
//   Configuration:
//     SDRAM_ARB_RR_EN  defined: round-robin between m0/m1 on a tie.
//                      undefined: fixed priority, m0 wins ties.
//     Refresh always takes priority over both requesters.
module sdram_arbiter #(
  parameter int unsigned ADDR_W         = 24,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned REFRESH_CYCLES = 195
) (
  input logic            clk_25mhz,
  input logic            rst,
  sdram_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  localparam int unsigned TIMER_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(REFRESH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ZERO   = {TIMER_W{1'b0}};
  localparam logic [TIMER_W-1:0] TIMER_ONE    = {{(TIMER_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q,       state_d;
  logic [TIMER_W-1:0] timer_q,      timer_d;
  logic              pending_q,     pending_d;
  logic              overrun_q,     overrun_d;
  logic              owner_q,       owner_d;
  logic              ctl_req_q,     ctl_req_d;
  logic              ctl_refresh_q, ctl_refresh_d;
  logic              ctl_we_q,      ctl_we_d;
  logic [ADDR_W-1:0] ctl_addr_q,    ctl_addr_d;
  logic [DATA_W-1:0] ctl_wdata_q,   ctl_wdata_d;
  logic              m0_ack_q,      m0_ack_d;
  logic              m1_ack_q,      m1_ack_d;
  logic [DATA_W-1:0] m0_rdata_q,    m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q,    m1_rdata_d;

  logic              expire_s;
  logic              pending_clr_s;
  logic              any_req_s;
  logic              grant_m1_s;
  logic              win_we_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_wdata_s;
  logic              master_grant_s;

`ifdef SDRAM_ARB_RR_EN
  logic              last_grant_q,  last_grant_d;
`endif

  assign any_req_s      = bus.m0_req | bus.m1_req;
  assign expire_s       = (timer_q == TIMER_ZERO);
  // A master is granted only from IDLE and only when no refresh is waiting.
  assign master_grant_s = (state_q == ST_IDLE) & ~pending_q & any_req_s;

  // Pick the requester that wins when both ask in the same IDLE cycle.
  always_comb begin
    grant_m1_s = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
`ifdef SDRAM_ARB_RR_EN
      grant_m1_s = (last_grant_q == OWN_M0);
`else
      grant_m1_s = 1'b0;
`endif
    end else if (bus.m1_req) begin
      grant_m1_s = 1'b1;
    end else begin
      grant_m1_s = 1'b0;
    end
  end

  // Mux the winning requester's command fields.
  always_comb begin
    if (grant_m1_s) begin
      win_we_s    = bus.m1_we;
      win_addr_s  = bus.m1_addr;
      win_wdata_s = bus.m1_wdata;
    end else begin
      win_we_s    = bus.m0_we;
      win_addr_s  = bus.m0_addr;
      win_wdata_s = bus.m0_wdata;
    end
  end

  // Free-running refresh interval down-counter, reloads after reaching zero.
  always_comb begin
    if (expire_s) begin
      timer_d = TIMER_RELOAD;
    end else begin
      timer_d = timer_q - TIMER_ONE;
    end
  end

  // Main transaction sequencer: IDLE -> BUSY -> (ACK) -> IDLE.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    ctl_req_d     = ctl_req_q;
    ctl_refresh_d = ctl_refresh_q;
    ctl_we_d      = ctl_we_q;
    ctl_addr_d    = ctl_addr_q;
    ctl_wdata_d   = ctl_wdata_q;
    m0_ack_d      = 1'b0;
    m1_ack_d      = 1'b0;
    m0_rdata_d    = m0_rdata_q;
    m1_rdata_d    = m1_rdata_q;
    pending_clr_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          state_d       = ST_BUSY;
          ctl_req_d     = 1'b1;
          ctl_refresh_d = 1'b1;
          ctl_we_d      = 1'b0;
          ctl_addr_d    = {ADDR_W{1'b0}};
          ctl_wdata_d   = {DATA_W{1'b0}};
        end else if (any_req_s) begin
          state_d       = ST_BUSY;
          owner_d       = grant_m1_s ? OWN_M1 : OWN_M0;
          ctl_req_d     = 1'b1;
          ctl_refresh_d = 1'b0;
          ctl_we_d      = win_we_s;
          ctl_addr_d    = win_addr_s;
          ctl_wdata_d   = win_wdata_s;
        end else begin
          state_d       = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (bus.ctl_done) begin
          ctl_req_d = 1'b0;
          if (ctl_refresh_q) begin
            // Refresh completes silently; no requester is acknowledged.
            ctl_refresh_d = 1'b0;
            pending_clr_s = 1'b1;
            state_d       = ST_IDLE;
          end else begin
            state_d = ST_ACK;
            if (owner_q == OWN_M1) begin
              m1_ack_d   = 1'b1;
              m1_rdata_d = bus.ctl_rdata;
            end else begin
              m0_ack_d   = 1'b1;
              m0_rdata_d = bus.ctl_rdata;
            end
          end
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d       = ST_IDLE;
        ctl_req_d     = 1'b0;
        ctl_refresh_d = 1'b0;
      end
    endcase
  end

  // Refresh bookkeeping: a new expiry beats a same-cycle refresh completion.
  always_comb begin
    if (expire_s) begin
      pending_d = 1'b1;
    end else if (pending_clr_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    overrun_d = overrun_q | (expire_s & pending_q);
  end

`ifdef SDRAM_ARB_RR_EN
  // Remember the most recent master grant for tie-breaking.
  always_comb begin
    if (master_grant_s) begin
      last_grant_d = grant_m1_s ? OWN_M1 : OWN_M0;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Last-grant register; m1 after reset so m0 wins the first tie.
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      last_grant_q <= OWN_M1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // State and output registers.
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= TIMER_RELOAD;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      owner_q       <= OWN_M0;
      ctl_req_q     <= 1'b0;
      ctl_refresh_q <= 1'b0;
      ctl_we_q      <= 1'b0;
      ctl_addr_q    <= {ADDR_W{1'b0}};
      ctl_wdata_q   <= {DATA_W{1'b0}};
      m0_ack_q      <= 1'b0;
      m1_ack_q      <= 1'b0;
      m0_rdata_q    <= {DATA_W{1'b0}};
      m1_rdata_q    <= {DATA_W{1'b0}};
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      owner_q       <= owner_d;
      ctl_req_q     <= ctl_req_d;
      ctl_refresh_q <= ctl_refresh_d;
      ctl_we_q      <= ctl_we_d;
      ctl_addr_q    <= ctl_addr_d;
      ctl_wdata_q   <= ctl_wdata_d;
      m0_ack_q      <= m0_ack_d;
      m1_ack_q      <= m1_ack_d;
      m0_rdata_q    <= m0_rdata_d;
      m1_rdata_q    <= m1_rdata_d;
    end
  end

  assign bus.ctl_req     = ctl_req_q;
  assign bus.ctl_refresh = ctl_refresh_q;
  assign bus.ctl_we      = ctl_we_q;
  assign bus.ctl_addr    = ctl_addr_q;
  assign bus.ctl_wdata   = ctl_wdata_q;
  assign bus.m0_ack      = m0_ack_q;
  assign bus.m1_ack      = m1_ack_q;
  assign bus.m0_rdata    = m0_rdata_q;
  assign bus.m1_rdata    = m1_rdata_q;
  assign bus.ref_overrun = overrun_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
//   Bench for sdram_arbiter with a short refresh interval. A transaction-level
//   model (who owns the controller, who is being acknowledged, refresh expiry
//   from cycle-count arithmetic) predicts every output each cycle; directed
//   scenarios add literal expectations, followed by randomized traffic.
module tb_sdram_arbiter;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int R  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sdram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .REFRESH_CYCLES(R)) dut (
    .clk_25mhz (clk),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // busy_who: -1 nothing in flight, 0/1 master, 2 refresh.
  // ack_who : -1 none, 0/1 master being acknowledged this cycle.
  bit              mdl_valid = 1'b0;
  int              cyc;
  int              busy_who;
  int              ack_who;
  bit              pend;
  bit              over;
  int              last_w;
  logic            m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW-1:0]   m_rd [2];

  always @(posedge clk) begin : model
    bit expire;
    bit p_next;
    int w;
    if (rst) begin
      mdl_valid = 1'b1;
      cyc = 0; busy_who = -1; ack_who = -1; pend = 1'b0; over = 1'b0; last_w = 1;
      m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rd[0] = '0; m_rd[1] = '0;
    end else if (mdl_valid) begin
      expire = ((cyc % R) == R - 1);
      p_next = pend;
      if (expire && pend) over = 1'b1;
      if (ack_who != -1) begin
        ack_who = -1;
      end else if (busy_who != -1) begin
        if (bus.ctl_done) begin
          if (busy_who == 2) begin
            p_next = 1'b0;
          end else begin
            m_rd[busy_who] = bus.ctl_rdata;
            ack_who = busy_who;
          end
          busy_who = -1;
        end
      end else if (pend) begin
        busy_who = 2;
        m_we = 1'b0;
      end else if (bus.m0_req || bus.m1_req) begin
`ifdef SDRAM_ARB_RR_EN
        if (bus.m0_req && bus.m1_req) w = 1 - last_w;
        else w = bus.m1_req ? 1 : 0;
        last_w = w;
`else
        w = bus.m0_req ? 0 : 1;
`endif
        busy_who = w;
        m_we    = (w == 1) ? bus.m1_we    : bus.m0_we;
        m_addr  = (w == 1) ? bus.m1_addr  : bus.m0_addr;
        m_wdata = (w == 1) ? bus.m1_wdata : bus.m0_wdata;
      end
      if (expire) p_next = 1'b1;
      pend = p_next;
      cyc++;
    end
  end

  // Compare every DUT output against the model, away from the clock edge.
  always @(negedge clk) begin
    if (mdl_valid) begin
      chk("ctl_req",     bus.ctl_req,     busy_who != -1);
      chk("ctl_refresh", bus.ctl_refresh, busy_who == 2);
      chk("m0_ack",      bus.m0_ack,      ack_who == 0);
      chk("m1_ack",      bus.m1_ack,      ack_who == 1);
      chk("m0_rdata",    bus.m0_rdata,    m_rd[0]);
      chk("m1_rdata",    bus.m1_rdata,    m_rd[1]);
      chk("ref_overrun", bus.ref_overrun, over);
      if (busy_who != -1) chk("ctl_we", bus.ctl_we, m_we);
      if (busy_who == 0 || busy_who == 1) begin
        chk("ctl_addr",  bus.ctl_addr,  m_addr);
        chk("ctl_wdata", bus.ctl_wdata, m_wdata);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    bus.ctl_done = 1'b0; bus.ctl_rdata = '0;
  endtask

  // Returns in cycle 0: first cycle with rst low, outputs at reset values.
  task automatic do_reset();
    clr_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [AW-1:0] exp_a;
  int            n_grants;
  logic          prev_req;

  initial begin
    clr_inputs();
    rst = 1'b1;
    step();
    step();
    step();
    rst = 1'b0;

    // A: single m0 read, done one cycle after ctl_req rises.
    chk("A_rst_ctl_req", bus.ctl_req, 1'b0);
    chk("A_rst_ovr", bus.ref_overrun, 1'b0);
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 24'h000123;
    step();                                  // cycle 1
    chk("A_c1_ctl_req", bus.ctl_req, 1'b1);
    chk("A_c1_addr", bus.ctl_addr, 32'h000123);
    chk("A_c1_we", bus.ctl_we, 1'b0);
    chk("A_c1_ref", bus.ctl_refresh, 1'b0);
    step();                                  // cycle 2
    bus.ctl_done = 1'b1; bus.ctl_rdata = 16'hBEEF;
    step();                                  // cycle 3
    bus.ctl_done = 1'b0; bus.ctl_rdata = 16'h0000;
    chk("A_c3_ack", bus.m0_ack, 1'b1);
    chk("A_c3_rdata", bus.m0_rdata, 32'h0000BEEF);
    chk("A_c3_m1ack", bus.m1_ack, 1'b0);
    chk("A_c3_ctl_req", bus.ctl_req, 1'b0);
    bus.m0_req = 1'b0;
    step();                                  // cycle 4
    chk("A_c4_ack", bus.m0_ack, 1'b0);
    chk("A_c4_rdata_hold", bus.m0_rdata, 32'h0000BEEF);

    // B: refresh only, every R cycles.
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 16) chk("B_c16_idle", bus.ctl_req, 1'b0);
      if (c == 17 || c == 33) begin
        chk("B_ref_req", bus.ctl_req, 1'b1);
        chk("B_ref_flag", bus.ctl_refresh, 1'b1);
        chk("B_ref_we", bus.ctl_we, 1'b0);
      end
      bus.ctl_done = bus.ctl_req;
    end
    chk("B_no_ovr", bus.ref_overrun, 1'b0);

    // C: controller stalls a refresh -> sticky overrun until rst.
    do_reset();
    for (int c = 1; c <= 60; c++) begin
      step();
      if (c == 31) chk("C_c31_ovr", bus.ref_overrun, 1'b0);
      if (c == 32) chk("C_c32_ovr", bus.ref_overrun, 1'b1);
      bus.ctl_done = (c >= 40) ? bus.ctl_req : 1'b0;
    end
    chk("C_ovr_sticky", bus.ref_overrun, 1'b1);
    bus.ctl_done = 1'b0;
    rst = 1'b1;
    step();
    chk("C_ovr_cleared", bus.ref_overrun, 1'b0);
    rst = 1'b0;

    // D: refresh expires while an m1 write is in flight; m0 waits behind it.
    do_reset();
    for (int c = 1; c <= 26; c++) begin
      step();
      bus.ctl_done = 1'b0;
      case (c)
        12: begin
          bus.m1_req = 1'b1; bus.m1_we = 1'b1;
          bus.m1_addr = 24'h0ABCDE; bus.m1_wdata = 16'h5A5A;
        end
        13: begin
          chk("D_m1_req", bus.ctl_req, 1'b1);
          chk("D_m1_wdata", bus.ctl_wdata, 32'h00005A5A);
          chk("D_m1_we", bus.ctl_we, 1'b1);
        end
        14: begin
          bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 24'h000777;
        end
        18: bus.ctl_done = 1'b1;
        19: begin
          chk("D_m1_ack", bus.m1_ack, 1'b1);
          chk("D_m0_noack", bus.m0_ack, 1'b0);
          bus.m1_req = 1'b0;
        end
        21: begin
          chk("D_ref_first", bus.ctl_refresh, 1'b1);
          chk("D_ref_req", bus.ctl_req, 1'b1);
          bus.ctl_done = 1'b1;
        end
        23: begin
          chk("D_m0_req", bus.ctl_req, 1'b1);
          chk("D_m0_notref", bus.ctl_refresh, 1'b0);
          chk("D_m0_addr", bus.ctl_addr, 32'h00000777);
          bus.ctl_done = 1'b1;
        end
        24: begin
          chk("D_m0_ack", bus.m0_ack, 1'b1);
          bus.m0_req = 1'b0;
        end
        default: ;
      endcase
    end

    // E: rst in BUSY aborts, then the refresh timer restarts from reload.
    do_reset();
    bus.m0_req = 1'b1; bus.m0_addr = 24'h000042;
    step();
    chk("E_busy", bus.ctl_req, 1'b1);
    step();
    rst = 1'b1;
    step();
    chk("E_abort_req", bus.ctl_req, 1'b0);
    chk("E_abort_ack0", bus.m0_ack, 1'b0);
    chk("E_abort_ack1", bus.m1_ack, 1'b0);
    rst = 1'b0;
    bus.m0_req = 1'b0;
    for (int n = 1; n <= 18; n++) begin
      step();
      if (n == 16) chk("E_n16_idle", bus.ctl_req, 1'b0);
      if (n == 17) chk("E_n17_ref", bus.ctl_refresh, 1'b1);
      bus.ctl_done = bus.ctl_req;
    end

    // F: both masters request continuously.
    do_reset();
    bus.m0_req = 1'b1; bus.m0_addr = 24'h000100;
    bus.m1_req = 1'b1; bus.m1_addr = 24'h000200;
    n_grants = 0;
    prev_req = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      step();
      if (bus.ctl_req && !prev_req) begin
`ifdef SDRAM_ARB_RR_EN
        exp_a = (n_grants % 2 == 0) ? 24'h000100 : 24'h000200;
`else
        exp_a = 24'h000100;
`endif
        if (n_grants < 4) chk("F_grant_addr", bus.ctl_addr, exp_a);
        n_grants++;
      end
      prev_req = bus.ctl_req;
      bus.ctl_done = bus.ctl_req;
    end
    chk("F_grant_count", n_grants, 5);

    // G: randomized traffic, stalls, spurious done and occasional resets.
    for (int seg = 0; seg < 2; seg++) begin
      do_reset();
      for (int c = 0; c < 1500; c++) begin
        step();
        if (rst) rst = 1'b0;
        if (bus.ctl_req) bus.ctl_done = ($urandom_range(0, 2) == 0);
        else             bus.ctl_done = ($urandom_range(0, 7) == 0);
        bus.ctl_rdata = DW'($urandom);
        if (bus.m0_req) begin
          if (bus.m0_ack) bus.m0_req = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          bus.m0_req = 1'b1; bus.m0_we = 1'($urandom);
          bus.m0_addr = AW'($urandom); bus.m0_wdata = DW'($urandom);
        end
        if (bus.m1_req) begin
          if (bus.m1_ack) bus.m1_req = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          bus.m1_req = 1'b1; bus.m1_we = 1'($urandom);
          bus.m1_addr = AW'($urandom); bus.m1_wdata = DW'($urandom);
        end
        if ($urandom_range(0, 499) == 0) begin
          rst = 1'b1;
          bus.m0_req = 1'b0;
          bus.m1_req = 1'b0;
        end
      end
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares one SDRAM controller between two single-word requesters, the pattern tester and the LED/readback path, and schedules periodic auto-refresh ahead of both. Sits between the requester logic and the SDRAM command sequencer that drives the sdram_* pins. It grants one transaction at a time, forwards it on a request/done handshake, and routes read data and the completion acknowledge back to the owner.

## Interface
- ADDR_W, 24, word address {bank[1:0], row[12:0], col[8:0]}
- DATA_W, 16, data width, matches sdram_d
- REFRESH_CYCLES, 195, refresh interval in clk_25mhz cycles (7.8 us)
- clk_25mhz  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- m0_req, m1_req  in  1  request; held with fields stable until the matching ack
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  ADDR_W  word address
- m0_wdata, m1_wdata  in  DATA_W  write data
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_rdata, m1_rdata  out  DATA_W  read data; valid during ack on reads
- ctl_req  out  1  command to controller; held until ctl_done
- ctl_refresh  out  1  1 = auto-refresh command (address and data don't care)
- ctl_we  out  1  write enable of the forwarded command
- ctl_addr  out  ADDR_W  forwarded address
- ctl_wdata  out  DATA_W  forwarded write data
- ctl_done  in  1  one-cycle completion pulse from controller
- ctl_rdata  in  DATA_W  read data; valid when ctl_done is high
- ref_overrun  out  1  sticky: refresh interval expired while a refresh was still pending

## Operation
- States: IDLE, BUSY, ACK.
- IDLE: arbitrate on the current cycle's inputs; the winner is registered into ctl_* and the state moves to BUSY.
  - Priority: refresh_pending first, then masters.
  - No request present: stay in IDLE.
- BUSY: ctl_req = 1 and ctl_* are held stable. On ctl_done:
  - Master transaction: latch ctl_rdata, go to ACK.
  - Refresh: clear refresh_pending, go to IDLE. No master ack is generated.
- ACK: the owner's mX_ack = 1 and mX_rdata = latched data for one cycle, ctl_req = 0, then IDLE.
- Refresh timer: free-running down-counter from REFRESH_CYCLES-1 that reloads at 0. It runs in every state.
  - At 0 it sets refresh_pending.
  - If refresh_pending is already set at 0, it also sets ref_overrun, which clears only on rst.
  - If expiry and refresh ctl_done fall in the same cycle, the set wins and refresh_pending stays 1.
- ctl_done outside BUSY is ignored.
- mX_rdata holds its last value between acks.
- Reset values: all outputs 0; state IDLE; timer = REFRESH_CYCLES-1; refresh_pending = 0; last_grant = m1, so m0 wins the first tie.
- rst mid-transaction: abort immediately. ctl_req is 0 the next cycle and no ack is issued. The controller shares rst.

## Timing
- Request sampled in IDLE at cycle 0 gives ctl_req = 1 from cycle 1.
- ctl_done at cycle k gives mX_ack at k+1 and IDLE at k+2.
- Minimum master latency, request to ack: 2 cycles (ctl_done in cycle 1).
- A master drops req no later than the cycle after its ack. IDLE at k+2 must not see a stale request.
- Back-to-back: a new request can be granted at k+2, so ctl_req is high again at k+3.
- The refresh grant waits at most for one in-flight master transaction.

## Configuration
- SDRAM_ARB_RR_EN defined: round-robin between masters. On a tie, the master not granted last wins; last_grant updates on every master grant.
- Not defined: fixed priority, m0 always wins ties. last_grant logic is removed.
- Refresh priority is unaffected by the macro in both cases.

## Test plan
- After rst, m0 read at 0x000123 with controller returning 0xBEEF, done in the cycle after ctl_req -> ctl_req at cycle 1, m0_ack and m0_rdata = 0xBEEF at cycle 3, m1_ack stays 0.
- m0 and m1 request continuously with SDRAM_ARB_RR_EN -> grants alternate m0, m1, m0, m1. Without the macro -> all grants go to m0 while m0_req is held.
- REFRESH_CYCLES = 8, no masters -> ctl_req with ctl_refresh = 1 every 8 cycles, ctl_we = 0, no acks.
- Refresh expires while an m1 write of 0x5A5A is in BUSY -> m1 completes with ack, then ctl_refresh is issued at the next IDLE ahead of a pending m0 request.
- Controller withholds ctl_done for 20 cycles with REFRESH_CYCLES = 8 -> ref_overrun = 1 and stays 1 until rst.
- rst asserted during BUSY -> ctl_req = 0 and all acks 0 the next cycle, timer reloaded, state IDLE.
